// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, FSM state encoding and the next-PC helper.
package cpu_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;
    localparam int OFFS_W = 10;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Branch offset is in words, so it is sign-extended and shifted left by one.
    function automatic logic [PC_W-1:0] pc_next(
        input logic [PC_W-1:0]   cur_pc,
        input logic              branch_en,
        input logic              en_pc_2,
        input logic [OFFS_W-1:0] offset
    );
        logic [PC_W-1:0] delta;
        if (branch_en)
            delta = {{(PC_W-OFFS_W-1){offset[OFFS_W-1]}}, offset, 1'b0};
        else if (en_pc_2)
            delta = PC_W'(2);
        else
            delta = '0;
        return cur_pc + delta;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC adder/mux shared by direct and pending PC updates.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]   cur_pc,
    input  logic              branch_en,
    input  logic              en_pc_2,
    input  logic [OFFS_W-1:0] offset,
    output logic [PC_W-1:0]   next_pc
);

    assign next_pc = pc_next(cur_pc, branch_en, en_pc_2, offset);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack fetch FSM and a one-deep pending PC-update slot.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
`ifdef FETCH_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_inc,
    input  logic              en_pc_2,
    input  logic              branch_en,
    input  logic [OFFS_W-1:0] pc_offset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    output logic              pend_drop,
    output logic              fault
);

    fetch_state_t state, state_nxt;

    logic              pend_valid;
    logic              pend_branch;
    logic              pend_pc_2;
    logic [OFFS_W-1:0] pend_offset;

    logic load_pc, use_pend, capture, clear_pend, drop, take_inst;
    logic              calc_branch, calc_pc_2;
    logic [OFFS_W-1:0] calc_offset;
    logic [PC_W-1:0]   next_pc;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;
    logic        timed_out;

    // Counter sits at zero outside FETCH, so it is cleared on every FETCH entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_FETCH)
            wait_cnt <= '0;
        else if (!imem_ack)
            wait_cnt <= wait_cnt + 16'd1;
    end

    assign timed_out = (wait_cnt == TIMEOUT_LAST);
    assign fault     = (state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        load_pc    = 1'b0;
        use_pend   = 1'b0;
        capture    = 1'b0;
        clear_pend = 1'b0;
        drop       = 1'b0;
        take_inst  = 1'b0;
        case (state)
            ST_START: begin
                state_nxt = ST_FETCH;
                if (pc_inc) begin
                    drop    = pend_valid;
                    capture = !pend_valid;
                end
            end
            ST_FETCH: begin
                if (pc_inc) begin
                    drop    = pend_valid;
                    capture = !pend_valid;
                end
                if (imem_ack) begin
                    take_inst = 1'b1;
                    state_nxt = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timed_out) begin
                    clear_pend = 1'b1;
                    state_nxt  = ST_FAULT;
                end
`endif
            end
            ST_HOLD: begin
                if (pend_valid) begin
                    use_pend   = 1'b1;
                    load_pc    = 1'b1;
                    clear_pend = 1'b1;
                    drop       = pc_inc;
                    state_nxt  = ST_FETCH;
                end else if (pc_inc) begin
                    load_pc   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = state;
        endcase
    end

    assign calc_branch = use_pend ? pend_branch : branch_en;
    assign calc_pc_2   = use_pend ? pend_pc_2   : en_pc_2;
    assign calc_offset = use_pend ? pend_offset : pc_offset;

    pc_next_calc u_pc_next_calc (
        .cur_pc    (pc),
        .branch_en (calc_branch),
        .en_pc_2   (calc_pc_2),
        .offset    (calc_offset),
        .next_pc   (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_START;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {RESET_PC[PC_W-1:1], 1'b0};
            instruction <= '0;
            pend_valid  <= 1'b0;
            pend_branch <= 1'b0;
            pend_pc_2   <= 1'b0;
            pend_offset <= '0;
            pend_drop   <= 1'b0;
        end else begin
            if (load_pc)
                pc <= next_pc;
            if (take_inst)
                instruction <= imem_rdata;
            if (clear_pend) begin
                pend_valid <= 1'b0;
            end else if (capture) begin
                pend_valid  <= 1'b1;
                pend_branch <= branch_en;
                pend_pc_2   <= en_pc_2;
                pend_offset <= pc_offset;
            end
            if (drop)
                pend_drop <= 1'b1;
        end
    end

    assign imem_req   = (state == ST_FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (timeout checks adapt to FETCH_TIMEOUT_EN).
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        pc_inc;
    logic        en_pc_2;
    logic        branch_en;
    logic [9:0]  pc_offset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instruction;
    logic        inst_valid;
    logic [15:0] pc;
    logic        pend_drop;
    logic        fault;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC(16'h0000)
`ifdef FETCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_inc      (pc_inc),
        .en_pc_2     (en_pc_2),
        .branch_en   (branch_en),
        .pc_offset   (pc_offset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pend_drop   (pend_drop),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pc_update(input logic br, input logic p2, input logic [9:0] offs);
        pc_inc    = 1'b1;
        branch_en = br;
        en_pc_2   = p2;
        pc_offset = offs;
        step();
        pc_inc    = 1'b0;
        branch_en = 1'b0;
        en_pc_2   = 1'b0;
        pc_offset = '0;
    endtask

    task automatic ack_with(input logic [15:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc_inc = 1'b0; en_pc_2 = 1'b0; branch_en = 1'b0;
        pc_offset = '0; imem_ack = 1'b0; imem_rdata = '0;
        step();
        step();
        check("rst_pc",        pc,          16'h0000);
        check("rst_instr",     instruction, 16'h0000);
        check("rst_valid",     inst_valid,  16'h0);
        check("rst_req",       imem_req,    16'h0);
        check("rst_pend_drop", pend_drop,   16'h0);
        check("rst_fault",     fault,       16'h0);

        // Test 1: START -> FETCH, ack two cycles after req rises
        rst = 1'b0;
        step();
        check("t1_req_rise", imem_req,   16'h1);
        check("t1_addr",     imem_addr,  16'h0000);
        check("t1_valid_lo", inst_valid, 16'h0);
        step();
        check("t1_req_wait", imem_req,   16'h1);
        ack_with(16'hA5A5);
        check("t1_instr",  instruction, 16'hA5A5);
        check("t1_valid",  inst_valid,  16'h1);
        check("t1_pc",     pc,          16'h0000);
        check("t1_req_lo", imem_req,    16'h0);
        // Ack while holding must be ignored
        ack_with(16'hFFFF);
        check("hold_ack_ignored", instruction, 16'hA5A5);
        check("hold_valid",       inst_valid,  16'h1);

        // Test 2: move to 0x0010 with a +8 word branch, then +2 and -2 words
        pc_update(1'b1, 1'b0, 10'd8);
        check("t2_pc_10", pc, 16'h0010);
        ack_with(16'h1010);
        pc_update(1'b0, 1'b1, 10'd0);
        check("t2_pc_12",   pc,         16'h0012);
        check("t2_req",     imem_req,   16'h1);
        check("t2_valid_0", inst_valid, 16'h0);
        ack_with(16'h1111);
        check("t2_valid_1", inst_valid, 16'h1);
        pc_update(1'b1, 1'b0, 10'h3FE);
        check("t2_pc_0e", pc, 16'h000E);
        ack_with(16'h2222);

        // Test 3: wrap-around, refetch, priority, negative branch wrap
        pc_update(1'b1, 1'b0, 10'h3F8);
        check("t3_pc_fffe", pc, 16'hFFFE);
        ack_with(16'h3333);
        pc_update(1'b0, 1'b1, 10'd0);
        check("t3_wrap_pc",   pc,        16'h0000);
        check("t3_wrap_addr", imem_addr, 16'h0000);
        ack_with(16'h3434);
        pc_update(1'b0, 1'b0, 10'd0);
        check("t3_refetch_pc",  pc,       16'h0000);
        check("t3_refetch_req", imem_req, 16'h1);
        ack_with(16'h3535);
        pc_update(1'b1, 1'b1, 10'd2);
        check("t3_branch_prio", pc, 16'h0004);
        ack_with(16'h3636);
        pc_update(1'b1, 1'b0, 10'h3FC);
        check("t3_neg_wrap", pc, 16'hFFFC);
        ack_with(16'h3737);

        // Test 4: two pc_inc during one FETCH -> first pending, second dropped
        pc_update(1'b0, 1'b1, 10'd0);
        check("t4_pc_fffe", pc, 16'hFFFE);
        pc_update(1'b0, 1'b1, 10'd0);
        check("t4_pend_pc_held", pc,        16'hFFFE);
        check("t4_no_drop_yet",  pend_drop, 16'h0);
        check("t4_still_req",    imem_req,  16'h1);
        pc_update(1'b1, 1'b0, 10'h010);
        check("t4_drop_set", pend_drop, 16'h1);
        check("t4_pc_same",  pc,        16'hFFFE);
        ack_with(16'h4444);
        check("t4_ack_instr", instruction, 16'h4444);
        check("t4_ack_valid", inst_valid,  16'h1);
        check("t4_ack_pc",    pc,          16'hFFFE);
        step();
        check("t4_pend_pc",    pc,         16'h0000);
        check("t4_pend_valid", inst_valid, 16'h0);
        check("t4_pend_req",   imem_req,   16'h1);
        check("t4_drop_stick", pend_drop,  16'h1);

        // Test 5: reset while a fetch waits, late ack ignored
        ack_with(16'h5555);
        pc_update(1'b0, 1'b1, 10'd0);
        check("t5_pre_pc", pc, 16'h0002);
        rst = 1'b1;
        step();
        check("t5_rst_pc",    pc,          16'h0000);
        check("t5_rst_req",   imem_req,    16'h0);
        check("t5_rst_valid", inst_valid,  16'h0);
        check("t5_rst_instr", instruction, 16'h0000);
        check("t5_rst_drop",  pend_drop,   16'h0);
        rst = 1'b0;
        ack_with(16'hBEEF);
        check("t5_late_instr", instruction, 16'h0000);
        check("t5_late_valid", inst_valid,  16'h0);
        check("t5_refetch",    imem_req,    16'h1);
        check("t5_addr",       imem_addr,   16'h0000);
        ack_with(16'h7777);
        check("t5_instr", instruction, 16'h7777);
        check("t5_valid", inst_valid,  16'h1);

        // Test 6: ack never arrives
        pc_update(1'b0, 1'b1, 10'd0);
        check("t6_pc", pc, 16'h0002);
        repeat (4) step();
`ifdef FETCH_TIMEOUT_EN
        check("t6_fault",     fault,      16'h1);
        check("t6_req_lo",    imem_req,   16'h0);
        check("t6_valid_lo",  inst_valid, 16'h0);
`else
        check("t6_no_fault",  fault,      16'h0);
        check("t6_req_wait",  imem_req,   16'h1);
`endif
        repeat (3) step();
`ifdef FETCH_TIMEOUT_EN
        check("t6_fault_sticky", fault,    16'h1);
        check("t6_req_sticky",   imem_req, 16'h0);
`else
        check("t6_still_no_fault", fault,    16'h0);
        check("t6_still_req",      imem_req, 16'h1);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_fault", fault, 16'h0);
        check("t6_rst_pc",    pc,    16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
